wb_spi_slave: RTL

// - Wishbone SPI slave (responder) for the lm32 SoC: the target-side counterpart of the SPI master.
// - Receives MSB-first bytes from an external master into an RX FIFO the CPU pops over Wishbone.
// - Returns a CPU-loaded TX byte on miso, one byte per transfer.
// - SPI mode 0: CPOL=0, CPHA=0; chip select is active low.

---
 rtl/wb_spi_slave.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_spi_slave.sv
// Wishbone SPI mode-0 responder: MSB-first RX FIFO popped by the CPU, one TX byte per transfer.
// Optional interrupt output and mask bit when SPI_SLAVE_IRQ_EN is defined.
module wb_spi_slave #(
    parameter int         RX_AW = 3,
    parameter logic [7:0] FILL  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    input  logic        wb_we_i,
    input  logic        spi_sck_i,
    input  logic        spi_mosi_i,
    input  logic        spi_cs_i,
    output logic        spi_miso_o
`ifdef SPI_SLAVE_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int             DEPTH    = 1 << RX_AW;
    localparam logic [RX_AW:0] FULL_CNT = (RX_AW + 1)'(DEPTH);

    logic [1:0] sck_s, mosi_s, cs_s;
    logic       sck_d, cs_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_s  <= 2'b00;
            mosi_s <= 2'b00;
            cs_s   <= 2'b11;
            sck_d  <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sck_s  <= {sck_s[0], spi_sck_i};
            mosi_s <= {mosi_s[0], spi_mosi_i};
            cs_s   <= {cs_s[0], spi_cs_i};
            sck_d  <= sck_s[1];
            cs_d   <= cs_s[1];
        end
    end

    logic active, sck_rise, sck_fall, cs_fall, cs_rise;
    assign active   = ~cs_s[1];
    assign sck_rise = sck_s[1] & ~sck_d;
    assign sck_fall = ~sck_s[1] & sck_d;
    assign cs_fall  = ~cs_s[1] & cs_d;
    assign cs_rise  = cs_s[1] & ~cs_d;

    logic       ack_reg, wb_req, wb_acc, rd_acc, wr_acc;
    logic [1:0] reg_sel;
    assign wb_req   = wb_stb_i & wb_cyc_i;
    assign wb_acc   = wb_req & ~ack_reg;
    assign rd_acc   = wb_acc & ~wb_we_i;
    assign wr_acc   = wb_acc & wb_we_i;
    assign reg_sel  = wb_adr_i[3:2];
    assign wb_ack_o = wb_req & ack_reg;

    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i, wb_dat_i};

    logic [7:0]       mem [DEPTH];
    logic [RX_AW-1:0] wr_ptr, rd_ptr;
    logic [RX_AW:0]   count;
    logic             rx_empty, rx_full, pop, push_req, push;
    logic [2:0]       bitcnt;
    logic [7:0]       rx_shift, tx_shift, tx_hold, tx_next, rx_byte;
    logic             tx_valid, tx_load, ovr, mask_rd;

    assign rx_empty = (count == '0);
    assign rx_full  = (count == FULL_CNT);
    assign pop      = rd_acc & (reg_sel == 2'd0) & ~rx_empty;
    assign rx_byte  = {rx_shift[6:0], mosi_s[1]};
    assign push_req = active & ~cs_fall & sck_rise & (bitcnt == 3'd7);
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push     = push_req & (~rx_full | pop);
    assign tx_next  = tx_valid ? tx_hold : FILL;
    assign tx_load  = cs_fall | push_req;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rx_byte;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop)
                count <= count + 1'b1;
            else if (pop & ~push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitcnt     <= '0;
            rx_shift   <= '0;
            tx_shift   <= FILL;
            spi_miso_o <= FILL[7];
        end else if (cs_fall) begin
            bitcnt     <= '0;
            tx_shift   <= tx_next;
            spi_miso_o <= tx_next[7];
        end else if (cs_rise) begin
            bitcnt <= '0;
        end else if (active) begin
            if (sck_rise) begin
                rx_shift <= rx_byte;
                bitcnt   <= bitcnt + 1'b1;
                if (bitcnt == 3'd7)
                    tx_shift <= tx_next;
                else
                    tx_shift <= {tx_shift[6:0], 1'b0};
            end else if (sck_fall) begin
                spi_miso_o <= tx_shift[7];
            end
        end
    end

    // A CPU write in the same cycle as a reload wins so the new byte is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_hold  <= '0;
            tx_valid <= 1'b0;
        end else if (wr_acc && reg_sel == 2'd1) begin
            tx_hold  <= wb_dat_i[7:0];
            tx_valid <= 1'b1;
        end else if (tx_load) begin
            tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovr <= 1'b0;
        else if (push_req & ~push)
            ovr <= 1'b1;
        else if (wr_acc && reg_sel == 2'd2 && wb_dat_i[4])
            ovr <= 1'b0;
    end

`ifdef SPI_SLAVE_IRQ_EN
    logic irq_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq_mask <= 1'b0;
        else if (wr_acc && reg_sel == 2'd2)
            irq_mask <= wb_dat_i[5];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= ~irq_mask & (~rx_empty | ovr);
    end

    assign mask_rd = irq_mask;
`else
    assign mask_rd = 1'b0;
`endif

    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        unique case (reg_sel)
            2'd0: rd_data = rx_empty ? 32'd0 : {24'd0, mem[rd_ptr]};
            2'd1: rd_data = '0;
            2'd2: rd_data = {26'd0, mask_rd, ovr, tx_valid,
                             rx_full, rx_empty, active};
            2'd3: rd_data = 32'(count);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_reg  <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            ack_reg <= wb_req;
            if (rd_acc)
                wb_dat_o <= rd_data;
        end
    end

endmodule
